// File: rtl/common_pkg.sv
// Shared types for the core: pipeline phase encoding, datapath word and the
// default warp count, plus a saturating increment used by the perf counters.
package common_pkg;

  localparam int WARPS_PER_CORE_DEF = 4;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  function automatic data_t sat_inc(input data_t v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_next_warp.sv
// Round-robin finder: first active warp after cur_warp, wrapping around,
// with cur_warp itself considered last.
module rr_next_warp
  import common_pkg::*;
#(
  parameter int WARPS = WARPS_PER_CORE_DEF,
  localparam int IW = $clog2(WARPS)
) (
  input  logic [WARPS-1:0] active,
  input  logic [IW-1:0]    cur_warp,
  output logic             found,
  output logic [IW-1:0]    next_idx
);

  logic [IW-1:0] cand_s;

  // Scan offsets 1..WARPS; the index wraps naturally because WARPS is a power of two
  always_comb begin
    found    = 1'b0;
    next_idx = cur_warp;
    cand_s   = {IW{1'b0}};
    for (int i = 1; i <= WARPS; i++) begin
      cand_s = cur_warp + IW'(i);
      if (!found && active[cand_s]) begin
        found    = 1'b1;
        next_idx = cand_s;
      end else begin
        found    = found;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: sequences the issue pipeline phases and round-robins
// it between active warps. Optional perf counters behind WARP_SCHED_PERF_EN.
module warp_scheduler
  import common_pkg::*;
#(
  parameter int WARPS_PER_CORE = WARPS_PER_CORE_DEF,
  localparam int IW = $clog2(WARPS_PER_CORE),
  localparam int CW = IW + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CW-1:0]             warp_count,
  output logic                      fetch_req,
  output data_t                     fetch_pc,
  input  logic                      fetch_valid,
  input  logic                      DMemEN,
  input  logic                      is_ret,
  output logic                      mem_req,
  input  logic                      mem_ready,
  input  data_t                     next_pc,
  output warp_state_t               warp_state,
  output logic [WARPS_PER_CORE-1:0] warp_enable,
  output logic [IW-1:0]             cur_warp,
  output logic                      busy,
  output logic                      done
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0]               cycle_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  localparam int W = WARPS_PER_CORE;

  warp_state_t   state_r;
  logic [IW-1:0] cur_warp_r;
  logic [W-1:0]  active_r;
  data_t         pc_r [W];
  logic          fetch_req_r;
  logic          mem_req_r;
  logic          done_r;
  logic          dmem_en_r;
  logic          is_ret_r;

  logic [CW-1:0] launch_n_s;
  logic [W-1:0]  launch_mask_s;
  logic [W-1:0]  cur_onehot_s;
  logic [W-1:0]  active_upd_s;
  logic          in_pipe_s;
  logic          start_ok_s;
  logic          found_s;
  logic [IW-1:0] next_idx_s;

  // Launch mask, current-warp decode and the post-RET active vector
  always_comb begin
    launch_n_s    = (warp_count > CW'(W)) ? CW'(W) : warp_count;
    launch_mask_s = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (CW'(i) < launch_n_s) begin
        launch_mask_s[i] = 1'b1;
      end else begin
        launch_mask_s[i] = 1'b0;
      end
    end
    cur_onehot_s             = {W{1'b0}};
    cur_onehot_s[cur_warp_r] = 1'b1;
    active_upd_s = is_ret_r ? (active_r & ~cur_onehot_s) : active_r;
    in_pipe_s    = (state_r != WARP_IDLE) && (state_r != WARP_DONE);
    start_ok_s   = start && !in_pipe_s;
  end

  rr_next_warp #(.WARPS(W)) u_rr (
    .active   (active_upd_s),
    .cur_warp (cur_warp_r),
    .found    (found_s),
    .next_idx (next_idx_s)
  );

  // Pipeline-phase FSM, per-warp PCs and registered handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= WARP_IDLE;
      cur_warp_r  <= {IW{1'b0}};
      active_r    <= {W{1'b0}};
      fetch_req_r <= 1'b0;
      mem_req_r   <= 1'b0;
      done_r      <= 1'b0;
      dmem_en_r   <= 1'b0;
      is_ret_r    <= 1'b0;
      for (int i = 0; i < W; i++) pc_r[i] <= 32'd0;
    end else begin
      case (state_r)
        WARP_IDLE, WARP_DONE: begin
          if (start_ok_s) begin
            active_r   <= launch_mask_s;
            cur_warp_r <= {IW{1'b0}};
            for (int i = 0; i < W; i++) pc_r[i] <= 32'd0;
            if (launch_n_s == {CW{1'b0}}) begin
              state_r <= WARP_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r     <= WARP_FETCH;
              fetch_req_r <= 1'b1;
              done_r      <= 1'b0;
            end
          end
        end
        WARP_FETCH: begin
          if (fetch_valid) begin
            state_r     <= WARP_DECODE;
            fetch_req_r <= 1'b0;
          end
        end
        WARP_DECODE: begin
          dmem_en_r <= DMemEN;
          is_ret_r  <= is_ret;
          state_r   <= WARP_REQUEST;
        end
        WARP_REQUEST: begin
          mem_req_r <= dmem_en_r;
          state_r   <= WARP_WAIT;
        end
        WARP_WAIT: begin
          if (!dmem_en_r || mem_ready) begin
            mem_req_r <= 1'b0;
            state_r   <= WARP_EXECUTE;
          end
        end
        WARP_EXECUTE: begin
          state_r <= WARP_UPDATE;
        end
        WARP_UPDATE: begin
          pc_r[cur_warp_r] <= next_pc;
          active_r         <= active_upd_s;
          if (found_s) begin
            cur_warp_r  <= next_idx_s;
            state_r     <= WARP_FETCH;
            fetch_req_r <= 1'b1;
          end else begin
            state_r <= WARP_DONE;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= WARP_IDLE;
          fetch_req_r <= 1'b0;
          mem_req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign warp_state  = state_r;
  assign cur_warp    = cur_warp_r;
  assign fetch_req   = fetch_req_r;
  assign mem_req     = mem_req_r;
  assign done        = done_r;
  assign busy        = in_pipe_s;
  assign warp_enable = in_pipe_s ? cur_onehot_s : {W{1'b0}};
  assign fetch_pc    = pc_r[cur_warp_r];

`ifdef WARP_SCHED_PERF_EN
  logic  stall_s;
  data_t cycle_cnt_r;
  data_t stall_cnt_r;

  assign stall_s = ((state_r == WARP_FETCH) && !fetch_valid) ||
                   ((state_r == WARP_WAIT) && mem_req_r && !mem_ready);

  // Busy-cycle and stall-cycle counters, saturating, cleared by an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else if (start_ok_s) begin
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (in_pipe_s) cycle_cnt_r <= sat_inc(cycle_cnt_r);
      if (stall_s)   stall_cnt_r <= sat_inc(stall_cnt_r);
    end
  end

  assign cycle_cnt = cycle_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler: the driver queues expected fetches and
// done latencies, a negedge monitor pops and compares them as the DUT produces them.
module tb_warp_scheduler;
  import common_pkg::*;

  localparam int W  = 4;
  localparam int IW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] warp_count = 3'd0;
  logic          fetch_req;
  data_t         fetch_pc;
  logic          fetch_valid = 1'b0;
  logic          DMemEN = 1'b0;
  logic          is_ret = 1'b0;
  logic          mem_req;
  logic          mem_ready = 1'b0;
  data_t         next_pc = 32'd0;
  warp_state_t   warp_state;
  logic [W-1:0]  warp_enable;
  logic [IW-1:0] cur_warp;
  logic          busy;
  logic          done;
`ifdef WARP_SCHED_PERF_EN
  logic [31:0]   cycle_cnt;
  logic [31:0]   stall_cnt;
`endif

  warp_scheduler #(.WARPS_PER_CORE(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .warp_count  (warp_count),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .fetch_valid (fetch_valid),
    .DMemEN      (DMemEN),
    .is_ret      (is_ret),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .next_pc     (next_pc),
    .warp_state  (warp_state),
    .warp_enable (warp_enable),
    .cur_warp    (cur_warp),
    .busy        (busy),
    .done        (done)
`ifdef WARP_SCHED_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int warp;
    int pc;
  } fetch_exp_t;

  fetch_exp_t fetch_q[$];
  int         done_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         ret_at[W];
  int         instr_cnt[W];
  bit         mem_mode = 1'b0;
  int         mem_delay = 0;
  int         wait_cnt = 0;
  int         mem_req_cycles = 0;
  data_t      last_pc = 32'd0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: zero-latency fetch, per-warp RET schedule, delayed mem_ready
  initial forever begin
    @(negedge clk);
    fetch_valid = fetch_req;
    if (warp_state == WARP_FETCH) last_pc = fetch_pc;
    next_pc = last_pc + 32'd4;
    if (warp_state == WARP_DECODE) begin
      DMemEN = mem_mode;
      is_ret = (instr_cnt[cur_warp] == ret_at[cur_warp]);
      instr_cnt[cur_warp]++;
    end else begin
      DMemEN = 1'b0;
      is_ret = 1'b0;
    end
    if (warp_state == WARP_WAIT && mem_req) begin
      mem_ready = (wait_cnt == mem_delay);
      wait_cnt++;
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end
    if (mem_req) mem_req_cycles++;
  end

  // Monitor: compare each new FETCH and each done rise against the queues
  initial begin
    warp_state_t prev_state;
    logic        prev_done;
    fetch_exp_t  e;
    int          d;
    prev_state = WARP_IDLE;
    prev_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (warp_state == WARP_FETCH && prev_state != WARP_FETCH) begin
        if (fetch_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got warp %0d pc %0d, expected no fetch", cur_warp, fetch_pc);
        end else begin
          e = fetch_q.pop_front();
          check("fetch_warp", longint'(cur_warp), longint'(e.warp));
          check("fetch_enable", longint'(warp_enable), longint'(1) << e.warp);
          check("fetch_pc", longint'(fetch_pc), longint'(e.pc));
        end
      end
      if (done && !prev_done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          d = done_q.pop_front();
          check("done_latency", longint'(cyc - start_cyc), longint'(d));
        end
      end
      prev_state = warp_state;
      prev_done  = done;
    end
  end

  task automatic setup(input bit mm, input int md, input int r0, input int r1,
                       input int r2, input int r3);
    mem_mode  = mm;
    mem_delay = md;
    ret_at[0] = r0;
    ret_at[1] = r1;
    ret_at[2] = r2;
    ret_at[3] = r3;
    for (int i = 0; i < W; i++) instr_cnt[i] = 0;
  endtask

  task automatic push_fetch(input int w, input int pc);
    fetch_exp_t e;
    e.warp = w;
    e.pc   = pc;
    fetch_q.push_back(e);
  endtask

  task automatic pulse_start(input int n, input bit record);
    @(negedge clk);
    warp_count = CW'(n);
    start      = 1'b1;
    if (record) start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=%0b expected 1", name, done);
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < W; i++) begin
      ret_at[i]    = 0;
      instr_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_state", longint'(warp_state), longint'(WARP_IDLE));
    check("rst_fetch_req", longint'(fetch_req), 0);
    check("rst_mem_req", longint'(mem_req), 0);
    check("rst_done", longint'(done), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_enable", longint'(warp_enable), 0);
    check("rst_cur_warp", longint'(cur_warp), 0);
    check("rst_fetch_pc", longint'(fetch_pc), 0);
    reset = 1'b1;

    // Single warp, RET on third instruction
    setup(1'b0, 0, 2, 99, 99, 99);
    push_fetch(0, 0); push_fetch(0, 4); push_fetch(0, 8);
    done_q.push_back(18);
    pulse_start(1, 1'b1);
    wait_done("single");

    // Four warps, each retires on its second instruction
    setup(1'b0, 0, 1, 1, 1, 1);
    for (int r = 0; r < 2; r++)
      for (int w = 0; w < W; w++) push_fetch(w, r * 4);
    done_q.push_back(48);
    pulse_start(4, 1'b1);
    wait_done("round_robin");

    // Warp 1 retires on its first instruction
    setup(1'b0, 0, 1, 0, 1, 1);
    push_fetch(0, 0); push_fetch(1, 0); push_fetch(2, 0); push_fetch(3, 0);
    push_fetch(0, 4); push_fetch(2, 4); push_fetch(3, 4);
    done_q.push_back(42);
    pulse_start(4, 1'b1);
    wait_done("retire_mid");

    // Memory stall of five cycles
    setup(1'b1, 5, 0, 99, 99, 99);
    push_fetch(0, 0);
    done_q.push_back(11);
    mem_req_cycles = 0;
    pulse_start(1, 1'b1);
    wait_done("mem_stall");
    check("mem_req_cycles", longint'(mem_req_cycles), 6);
`ifdef WARP_SCHED_PERF_EN
    check("stall_cnt", longint'(stall_cnt), 5);
    check("cycle_cnt", longint'(cycle_cnt), 11);
`endif

    // Reset while waiting on memory
    setup(1'b1, 100, 0, 99, 99, 99);
    push_fetch(0, 0);
    pulse_start(1, 1'b1);
    t = 0;
    while (warp_state != WARP_WAIT && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reached_wait", longint'(warp_state), longint'(WARP_WAIT));
    reset = 1'b0;
    #1;
    check("rst_mid_state", longint'(warp_state), longint'(WARP_IDLE));
    check("rst_mid_mem_req", longint'(mem_req), 0);
    check("rst_mid_fetch_req", longint'(fetch_req), 0);
    check("rst_mid_enable", longint'(warp_enable), 0);
    @(negedge clk);
    reset = 1'b1;
    mem_mode = 1'b0;
    done_q.push_back(0);
    pulse_start(0, 1'b1);
    wait_done("zero_warps");
    check("zero_warps_state", longint'(warp_state), longint'(WARP_DONE));

    // Clamp warp_count=7 to four warps, ignore a start while busy
    setup(1'b0, 0, 0, 0, 0, 0);
    for (int w = 0; w < W; w++) push_fetch(w, 0);
    done_q.push_back(24);
    pulse_start(7, 1'b1);
    repeat (6) @(negedge clk);
    check("busy_mid_run", longint'(busy), 1);
    pulse_start(1, 1'b0);
    wait_done("clamp");

    repeat (3) @(negedge clk);
    check("fetch_q_drained", longint'(fetch_q.size()), 0);
    check("done_q_drained", longint'(done_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Per-core warp scheduler that sequences the shared issue pipeline through the `warp_state_t` phases and time-multiplexes it round-robin between the core's warps. It drives `warp_state` and the one-hot `warp_enable` that gate the per-warp scalar and vector register files. It also owns each warp's PC, handshakes with the instruction fetcher and the LSU, and retires warps on RET.

## Interface
- `WARPS_PER_CORE`, default 4, number of warps sharing this pipeline (power of two, ≥2)
- `clk` in 1: core clock
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: launch pulse, honoured only in IDLE or DONE
- `warp_count` in $clog2(WARPS_PER_CORE)+1: warps to launch; values above `WARPS_PER_CORE` clamp to `WARPS_PER_CORE`
- `fetch_req` out 1: instruction fetch request
- `fetch_pc` out 32: PC of the current warp
- `fetch_valid` in 1: instruction returned
- `DMemEN` in 1: decoded instruction uses memory
- `is_ret` in 1: decoded instruction is RET
- `mem_req` out 1: LSU request
- `mem_ready` in 1: LSU access complete
- `next_pc` in 32 (`data_t`): PC computed by the branch unit
- `warp_state` out `warp_state_t`: current pipeline phase
- `warp_enable` out WARPS_PER_CORE: one-hot select of the current warp
- `cur_warp` out $clog2(WARPS_PER_CORE): current warp index
- `busy` out 1: asserted from FETCH through UPDATE
- `done` out 1: all launched warps retired

## Operation
- FSM states: IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE.
- **IDLE/DONE + `start`:**
  - Mark warps 0..n-1 active, where n is the clamped `warp_count`.
  - Clear all PCs to 0, set `cur_warp`=0, clear `done`.
  - If n=0, go to DONE; otherwise go to FETCH.
- **FETCH:** `fetch_req`=1 and `fetch_pc`=pc[cur_warp] are held until `fetch_valid`, then go to DECODE.
- **DECODE:** 1 cycle. Latch `DMemEN` and `is_ret` at the end of this cycle.
- **REQUEST:** 1 cycle. Register files read operands.
- **WAIT:**
  - If the latched `DMemEN`=1: hold `mem_req`=1 until `mem_ready`, then go to EXECUTE.
  - If the latched `DMemEN`=0: 1 cycle, no `mem_req`.
- **EXECUTE:** 1 cycle.
- **UPDATE:** 1 cycle. Register files write back.
  - pc[cur_warp] <= `next_pc`.
  - If the latched `is_ret`=1, clear active[cur_warp].
  - Next warp = first active index scanning cur_warp+1, cur_warp+2, … with wrap-around, cur_warp itself checked last.
  - If one is found, load it into `cur_warp` and go to FETCH; otherwise go to DONE.
- **DONE:** `done`=1 is held until a new `start`.
- `warp_enable` = one-hot of `cur_warp` in FETCH..UPDATE; all zeros in IDLE and DONE.
- `start` is ignored while `busy`.
- Reset mid-operation:
  - Immediately returns to IDLE and clears active flags, PCs, and all outputs.
  - Any pending `mem_req` or `fetch_req` is dropped.

## Timing
- All outputs are registered except `warp_enable`, `fetch_pc`, and `busy`, which decode from registered state.
- Reset values: all outputs 0, `warp_state`=WARP_IDLE.
- Minimum instruction latency is 6 cycles (FETCH through UPDATE), with `fetch_valid` and `mem_ready` each arriving in the first cycle their request is high.
- A response in the same cycle as its request's first assertion is legal; the FSM advances on the next edge.
- `start` → FETCH with `fetch_req` high on the next edge.
- Warp switch: the UPDATE of warp k is immediately followed by FETCH of the next warp, with no bubble.
- Last warp retired: UPDATE → DONE on the next edge; `done` rises in that cycle.

## Configuration
- `WARP_SCHED_PERF_EN` defined: adds outputs `cycle_cnt` (32) and `stall_cnt` (32).
  - `cycle_cnt` counts every `busy` cycle.
  - `stall_cnt` counts FETCH cycles without `fetch_valid` plus WAIT cycles with `mem_req` and no `mem_ready`.
  - Both clear on an accepted `start` and on reset, and saturate at all-ones.
- Undefined: these ports and counters are absent. FSM behaviour is identical either way.

## Structure
- `common_pkg` holds:
  - `warp_state_t` (add states here only), `data_t`.
  - The `WARPS_PER_CORE` default constant.
- Sub-module `rr_next_warp`: combinational round-robin finder. Inputs are the active vector and `cur_warp`; outputs are `found` and `next_idx`.
- The FSM, per-warp PC array, and perf counters live in `warp_scheduler`.

## Test plan
- **Single warp, three non-memory instructions, RET on the 3rd:**
  - Stimulus: `warp_count`=1, zero-latency `fetch_valid`, `next_pc` = pc+4.
  - Required: `done` rises 18 cycles after `start`; `fetch_pc` sequence is 0, 4, 8.
- **Round-robin across four warps:**
  - Stimulus: `warp_count`=4, no RETs.
  - Required: `cur_warp` sequence 0, 1, 2, 3, 0; `warp_enable` 0001, 0010, 0100, 1000, 0001.
- **Retire in the middle:**
  - Stimulus: warp 1 executes RET on its first instruction.
  - Required: the next round's order is 0, 2, 3; warp 1 never appears again.
- **Memory stall:**
  - Stimulus: `DMemEN`=1, `mem_ready` delayed 5 cycles.
  - Required: `mem_req` high for 6 cycles; `stall_cnt`=5 when `WARP_SCHED_PERF_EN` is defined.
- **Reset mid-WAIT:**
  - Stimulus: deassert `reset` in WAIT.
  - Required: `warp_state`=WARP_IDLE and `mem_req`=0 immediately; `start` with `warp_count`=0 then gives `done` on the next edge.
- **Clamp and ignore:**
  - Stimulus: `warp_count`=7 with `WARPS_PER_CORE`=4.
  - Required: exactly 4 warps active; a second `start` while `busy` changes nothing.
